dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
// Holds the FSM state encoding and the saturating error-counter helper.
package dmem_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 10;
  localparam int DEPTH_DEF   = 512;
  localparam int LATENCY_DEF = 2;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read on enable.
// Contents are never cleared; the read register only moves when i_re is high.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Request/response front end for the data memory: one transaction in flight,
// fixed latency, out-of-range addresses answered with an error response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        err_count
);

  localparam int              IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam bit              DIRECT = (LATENCY == 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_we;
  logic               r_err;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [7:0]         r_err_count;

  logic               w_legal;
  logic               w_accept;
  logic               w_wr_en;
  logic               w_rd_en;
  logic [IDX_W-1:0]   w_arr_addr;
  logic [DATA_W-1:0]  w_arr_rdata;

  assign w_legal  = ({1'b0, req_addr} < LIMIT);
  assign w_accept = reset && req_valid && r_req_ready && (r_state == IDLE);
  assign w_wr_en  = w_accept && req_we && w_legal;

  // The array is sampled on the edge that enters RESP: the accept edge itself
  // when there is no wait state, otherwise the last WAIT edge.
  assign w_rd_en = reset && (
      (DIRECT && w_accept && !req_we && w_legal) ||
      ((r_state == WAIT) && (r_cnt == ONE) && !r_we && !r_err));

  assign w_arr_addr = (r_state == IDLE) ? req_addr[IDX_W-1:0] : r_idx;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_re    (w_rd_en),
    .i_addr  (w_arr_addr),
    .i_wdata (req_wdata),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx       <= req_addr[IDX_W-1:0];
            r_we        <= req_we;
            r_err       <= !w_legal;
            r_req_ready <= 1'b0;
            if (DIRECT) begin
              r_cnt       <= '0;
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_cnt   <= LOAD;
              r_state <= WAIT;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - ONE;
          if (r_cnt == ONE) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          // Completion returns to IDLE; the next accept is one edge later.
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            if (r_err) begin
              r_err_count <= sat_inc(r_err_count);
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_valid && r_err;
  assign rsp_rdata = (r_rsp_valid && !r_we && !r_err) ? w_arr_rdata : '0;
  assign err_count = r_err_count;

endmodule
